// File: rtl/parity_pkg.sv
// Shared types and line levels for the parity frame transmitter and its future receiver.
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_frame_tx_if.sv
// Valid/ready word handshake between the parallel parity logic and the serialiser.
interface parity_frame_tx_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] data_in;
    logic              odd_sel;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_in,
        output odd_sel,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  odd_sel,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/bit_timer.sv
// Free-running bit-period counter: tick marks the last clock of a bit, pre_tick the one before it.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [TW-1:0] count;

    assign tick = (count == TW'(CLKS_PER_BIT - 1));

    // With a one-clock bit every cycle is both the last and the one before the last.
    generate
        if (CLKS_PER_BIT == 1) begin : g_single
            assign pre_tick = 1'b1;
        end else begin : g_multi
            assign pre_tick = (count == TW'(CLKS_PER_BIT - 2));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end
endmodule

// File: rtl/parity_frame_tx.sv
// Serialises one data word per frame: start bit, data LSB first, parity bit, stop bit.
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    parity_frame_tx_if.slave      up,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_t         state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shifted;
    logic [IW-1:0]     bit_idx;
    logic              parity_bit;
    logic              accept;
    logic              timer_clear;
    logic              tick;
    logic              pre_tick;

    // Ready depends only on the state register, never on data_valid.
    assign up.data_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign accept        = up.data_valid && (state == IDLE);
    assign timer_clear   = (state == IDLE);
    assign shifted       = shift_reg >> 1;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // frame_done is raised one clock early so it lands in the final stop-bit cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            serial_out <= IDLE_LEVEL;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    serial_out <= IDLE_LEVEL;
                    if (accept) begin
                        shift_reg  <= up.data_in;
                        parity_bit <= (^up.data_in) ^ up.odd_sel;
                        bit_idx    <= '0;
                        serial_out <= START_BIT;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        serial_out <= shift_reg[0];
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == IW'(DATA_W - 1)) begin
                            bit_idx    <= '0;
                            serial_out <= parity_bit;
                            state      <= PARITY;
                        end else begin
                            bit_idx    <= bit_idx + IW'(1);
                            shift_reg  <= shifted;
                            serial_out <= shifted[0];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        serial_out <= STOP_BIT;
                        frame_done <= (CLKS_PER_BIT == 1);
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        serial_out <= IDLE_LEVEL;
                        state      <= IDLE;
                    end else begin
                        frame_done <= pre_tick;
                    end
                end
                default: begin
                    serial_out <= IDLE_LEVEL;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench: two transmitters (4 and 1 clocks per bit) against a frame-level reference model.
module tb_parity_frame_tx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    parity_frame_tx_if #(.DATA_W(4)) if4 ();
    parity_frame_tx_if #(.DATA_W(4)) if1 ();

    logic so4, busy4, done4;
    logic so1, busy1, done1;

    parity_frame_tx #(
        .DATA_W       (4),
        .CLKS_PER_BIT (4)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .up         (if4.slave),
        .serial_out (so4),
        .busy       (busy4),
        .frame_done (done4)
    );

    parity_frame_tx #(
        .DATA_W       (4),
        .CLKS_PER_BIT (1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .up         (if1.slave),
        .serial_out (so1),
        .busy       (busy1),
        .frame_done (done1)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic get_so(input int sel);
        return (sel == 1) ? so1 : so4;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? busy1 : busy4;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 1) ? done1 : done4;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 1) ? if1.data_ready : if4.data_ready;
    endfunction

    // Reference frame, index 0 first on the wire: start, d[0..3], parity, stop.
    function automatic logic [6:0] frame_bits(input logic [3:0] d, input logic odd);
        logic p;
        p = (($countones(d) % 2) == 1) ^ odd;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic drive(input int sel, input logic v, input logic [3:0] d, input logic o);
        if (sel == 1) begin
            if1.data_valid = v;
            if1.data_in    = d;
            if1.odd_sel    = o;
        end else begin
            if4.data_valid = v;
            if4.data_in    = d;
            if4.odd_sel    = o;
        end
    endtask

    task automatic wait_ready(input int sel, input string tag);
        int n;
        n = 0;
        while (get_ready(sel) !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (get_ready(sel) !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s ready_timeout: data_ready=%b after %0d cycles, want 1", tag, get_ready(sel), n);
        end
    endtask

    // Sends one word and checks every cycle of the frame plus the idle cycle after it.
    task automatic run_frame(input int sel, input logic [3:0] d, input logic o, input string tag);
        int         cpb;
        int         len;
        logic [6:0] bits;
        logic       es;
        logic       ed;
        cpb  = (sel == 1) ? 1 : 4;
        len  = 7 * cpb;
        bits = frame_bits(d, o);
        wait_ready(sel, tag);
        drive(sel, 1'b1, d, o);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 4'($urandom), 1'($urandom));
        for (int j = 0; j <= len; j++) begin
            es = (j < len) ? bits[j / cpb] : 1'b1;
            ed = (j == len - 1);
            total += 2;
            if (get_so(sel) !== es) begin
                bad++;
                $display("[TB] FAIL %s serial_out cycle %0d: got %b want %b", tag, j, get_so(sel), es);
            end
            if (get_done(sel) !== ed) begin
                bad++;
                $display("[TB] FAIL %s frame_done cycle %0d: got %b want %b", tag, j, get_done(sel), ed);
            end
            if (j == 0 || j == len) begin
                total += 2;
                if (get_busy(sel) !== (j < len)) begin
                    bad++;
                    $display("[TB] FAIL %s busy cycle %0d: got %b want %b", tag, j, get_busy(sel), (j < len));
                end
                if (get_ready(sel) !== (j == len)) begin
                    bad++;
                    $display("[TB] FAIL %s data_ready cycle %0d: got %b want %b", tag, j, get_ready(sel), (j == len));
                end
            end
            if (j < len) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 4'h0, 1'b0);
        drive(1, 1'b0, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            total += 3;
            if (get_so(s) !== 1'b1) begin
                bad++;
                $display("[TB] FAIL reset_serial dut%0d: got %b want 1", s, get_so(s));
            end
            if (get_busy(s) !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_busy dut%0d: got %b want 0", s, get_busy(s));
            end
            if (get_done(s) !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_done dut%0d: got %b want 0", s, get_done(s));
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                total++;
                if (get_so(s) !== 1'b1 || get_ready(s) !== 1'b1 || get_busy(s) !== 1'b0 || get_done(s) !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL idle dut%0d cycle %0d: so/ready/busy/done=%b%b%b%b want 1100",
                             s, c, get_so(s), get_ready(s), get_busy(s), get_done(s));
                end
            end
        end
    endtask

    task automatic test_known_frame();
        run_frame(0, 4'b1011, 1'b0, "frame_1011_even");
    endtask

    task automatic test_parity_modes();
        run_frame(0, 4'b0000, 1'b1, "par_0000_odd");
        run_frame(0, 4'b0110, 1'b0, "par_0110_even");
        run_frame(0, 4'b0110, 1'b1, "par_0110_odd");
        for (int i = 0; i < 6; i++) begin
            run_frame(0, 4'($urandom), 1'($urandom), $sformatf("par_rand%0d", i));
        end
    endtask

    // Valid held high with a fresh word every cycle; only the words at 29-cycle spacing are sent.
    task automatic test_back_to_back();
        logic [3:0] words [87];
        logic       odds  [87];
        logic [6:0] bits;
        logic       es;
        int         f;
        int         j;
        wait_ready(0, "b2b_start");
        for (int t = 0; t < 87; t++) begin
            words[t] = 4'($urandom);
            odds[t]  = 1'($urandom);
            drive(0, 1'b1, words[t], odds[t]);
            @(posedge clk);
            #1;
            f    = t / 29;
            j    = t % 29;
            bits = frame_bits(words[29 * f], odds[29 * f]);
            es   = (j < 28) ? bits[j / 4] : 1'b1;
            total += 3;
            if (so4 !== es) begin
                bad++;
                $display("[TB] FAIL b2b serial_out t=%0d: got %b want %b", t, so4, es);
            end
            if (done4 !== (j == 27)) begin
                bad++;
                $display("[TB] FAIL b2b frame_done t=%0d: got %b want %b", t, done4, (j == 27));
            end
            if (if4.data_ready !== (j == 28)) begin
                bad++;
                $display("[TB] FAIL b2b data_ready t=%0d: got %b want %b", t, if4.data_ready, (j == 28));
            end
        end
        drive(0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        wait_ready(0, "midrst_start");
        drive(0, 1'b1, 4'($urandom), 1'($urandom));
        @(posedge clk);
        #1;
        drive(0, 1'b0, 4'h0, 1'b0);
        repeat (13) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (busy4 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_precond busy: got %b want 1", busy4);
        end
        #2;
        rst = 1'b1;
        #1;
        total += 3;
        if (so4 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_async serial_out: got %b want 1", so4);
        end
        if (busy4 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_async busy: got %b want 0", busy4);
        end
        if (done4 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_async frame_done: got %b want 0", done4);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (so4 !== 1'b1 || done4 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midrst_hold cycle %0d: serial_out=%b frame_done=%b want 1,0", c, so4, done4);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (done4 !== 1'b0 || busy4 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midrst_after cycle %0d: frame_done=%b busy=%b want 0,0", c, done4, busy4);
            end
        end
        run_frame(0, 4'($urandom), 1'($urandom), "midrst_next_frame");
    endtask

    task automatic test_cpb1();
        run_frame(1, 4'b1000, 1'b0, "cpb1_1000_even");
        for (int i = 0; i < 4; i++) begin
            run_frame(1, 4'($urandom), 1'($urandom), $sformatf("cpb1_rand%0d", i));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_known_frame();
        test_parity_modes();
        test_back_to_back();
        test_reset_mid_frame();
        test_cpb1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Downstream serialising stage for the 4-bit parity generator.
- Accepts a data word over a valid/ready handshake and computes its parity bit internally, even or odd per word.
- Shifts out a UART-style frame, LSB first: start bit, data bits, parity bit, stop bit.
- Each bit is held for a programmable number of clocks.
- Sits between the parallel data/parity logic and the serial link pin.

Parameters:
DATA_W, 4, width of the data word (>=1)
CLKS_PER_BIT, 4, clock cycles each frame bit is held on serial_out (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  DATA_W  word to transmit; sampled only on accept
odd_sel  input  1  parity mode; sampled only on accept (0 = even, 1 = odd)
data_valid  input  1  upstream has a word
data_ready  output  1  block can accept a word
serial_out  output  1  serial line; idles high
busy  output  1  frame in progress (any state other than IDLE)
frame_done  output  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Clocking/reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: state=IDLE, serial_out=1, busy=0, frame_done=0, data_ready=1 (once rst deasserts), counters=0.
- Reset mid-frame: abort immediately, serial_out=1, no frame_done. The latched word is discarded.
- Accept: occurs at a rising edge where data_valid && data_ready.
  - data_ready = (state==IDLE); it is registered-state decoded with no combinational path from data_valid.
  - On accept, latch data_in into a shift register and latch parity.
  - Parity = XOR of all data_in bits when odd_sel=0; its inverse when odd_sel=1.
- States and transitions:
  - IDLE -> START on accept.
  - START -> DATA -> PARITY -> STOP -> IDLE.
  - Each state transition occurs when the bit-timer reaches CLKS_PER_BIT-1.
  - DATA repeats DATA_W times; a bit index counts 0..DATA_W-1 and the shift register shifts right each bit.
- serial_out per state (registered, no glitches): START=0, DATA=current LSB, PARITY=latched parity, STOP=1, IDLE=1.
- Timing, with accept at edge k:
  - serial_out=0 from edge k through k+CLKS_PER_BIT.
  - data bit i is driven from edge k+(1+i)*CLKS_PER_BIT.
  - parity is driven from edge k+(1+DATA_W)*CLKS_PER_BIT.
  - stop is driven from edge k+(2+DATA_W)*CLKS_PER_BIT.
  - frame_done is high for exactly the cycle following edge k+(3+DATA_W)*CLKS_PER_BIT-1.
  - At edge k+(3+DATA_W)*CLKS_PER_BIT, state returns to IDLE and data_ready=1.
- Minimum accept-to-accept spacing: (3+DATA_W)*CLKS_PER_BIT+1 cycles. IDLE always lasts at least one cycle, so there is no same-edge re-accept.
- data_valid/data_in/odd_sel while busy: ignored; upstream must hold data_valid until it sees data_ready.
- CLKS_PER_BIT=1: every state lasts exactly one cycle; the bit-timer is a constant 0.
- Widths:
  - bit-timer width = $clog2(CLKS_PER_BIT), minimum 1.
  - bit index width = $clog2(DATA_W), minimum 1.
  - Both wrap to 0 at their terminal count; neither ever exceeds it.

Decomposition:
- Shared package parity_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- One natural sub-module, bit_timer:
  - CLKS_PER_BIT counter with clear input and a tick output.
  - Shared later by the matching receiver.
- FSM, shift register and parity calculation stay in parity_frame_tx.

Test Plan:
- Reset, then idle 10 cycles -> serial_out=1, data_ready=1, busy=0, frame_done=0 throughout.
- data_in=4'b1011, odd_sel=0, one-cycle valid (CLKS_PER_BIT=4) -> serial_out sequence 0,1,1,0,1,1,1, each bit held 4 cycles. Then: frame_done pulses once at cycle 28 after accept; data_ready returns at cycle 28.
- data_in=4'b0000, odd_sel=1 -> parity bit=1. data_in=4'b0110, odd_sel=0 -> parity bit=0. data_in=4'b0110, odd_sel=1 -> parity bit=1.
- data_valid held high with new data_in every cycle -> exactly one word is accepted per frame, with accepts 29 cycles apart. Words presented while busy do not alter the frame in flight.
- rst asserted in the middle of the DATA state (bit 2) -> serial_out=1 and busy=0 without waiting for a clock edge. No frame_done. The next accepted word transmits a complete, correct frame.
- Rebuild with CLKS_PER_BIT=1, data_in=4'b1000, even parity -> 7-cycle frame 0,0,0,0,1,1,1; frame_done in cycle 7.
